codeword_serializer: RTL

- Downstream of the encoder; consumes its per-cycle parallel codeword word (SYM_NUM symbols of SYM_WIDTH bits).
- Buffers words in a small FIFO and re-emits them as a narrower ready/valid symbol stream (OUT_SYMS symbols per beat) for the link/framing logic.
- Tags each beat with start/end-of-codeword markers derived from a word counter. Reports overflow, because the encoder cannot be stalled.

---
 rtl/codeword_serializer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/codeword_serializer.sv
// Word FIFO plus output register that splits encoder codeword words into
// narrower ready/valid beats tagged with codeword start/end markers.
module codeword_serializer #(
    parameter int SYM_NUM    = 4,
    parameter int SYM_WIDTH  = 4,
    parameter int OUT_SYMS   = 2,
    parameter int CW_WORDS   = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [SYM_NUM*SYM_WIDTH-1:0]      in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OUT_SYMS*SYM_WIDTH-1:0]     out_data,
    output logic                              out_sop,
    output logic                              out_eop,
    output logic                              overflow,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

    localparam int W     = SYM_NUM * SYM_WIDTH;
    localparam int OW    = OUT_SYMS * SYM_WIDTH;
    localparam int BEATS = SYM_NUM / OUT_SYMS;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int CW    = $clog2(CW_WORDS);

    typedef struct packed {
        logic [W-1:0] data;
        logic         sop;
        logic         eop;
    } entry_t;

    entry_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            ovf_q, ovf_d;
    logic            vld_q, vld_d;
    entry_t          word_q, word_d;
    logic [BW-1:0]   beat_q, beat_d;

    logic   fifo_empty;
    logic   fifo_full;
    logic   last_beat;
    logic   xfer;
    logic   pop;
    logic   push;
    logic   drop;
    entry_t in_entry;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
    assign last_beat  = (beat_q == BW'(BEATS - 1));
    assign xfer       = vld_q & out_ready;
    assign pop        = ~fifo_empty & (~vld_q | (xfer & last_beat));
    assign push       = in_valid & (~fifo_full | pop);
    assign drop       = in_valid & fifo_full & ~pop;

    // Tags follow the encoder's word count, dropped words included.
    always_comb begin
        in_entry.data = in_data;
        in_entry.sop  = (wcnt_q == '0);
        in_entry.eop  = (wcnt_q == CW'(CW_WORDS - 1));
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        wcnt_d   = wcnt_q;
        ovf_d    = ovf_q | drop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (in_valid) begin
            if (wcnt_q == CW'(CW_WORDS - 1)) begin
                wcnt_d = '0;
            end else begin
                wcnt_d = wcnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        vld_d  = vld_q;
        word_d = word_q;
        beat_d = beat_q;
        if (xfer) begin
            if (last_beat) begin
                vld_d  = 1'b0;
                beat_d = '0;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
        if (pop) begin
            word_d = mem_q[rd_ptr_q];
            beat_d = '0;
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            wcnt_q   <= '0;
            ovf_q    <= 1'b0;
            vld_q    <= 1'b0;
            word_q   <= '0;
            beat_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            wcnt_q   <= wcnt_d;
            ovf_q    <= ovf_d;
            vld_q    <= vld_d;
            word_q   <= word_d;
            beat_q   <= beat_d;
        end
    end

    // Storage only; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    always_comb begin
        out_data = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BW'(b)) begin
                out_data = word_q.data[W-1-b*OW -: OW];
            end
        end
        if (!vld_q) begin
            out_data = '0;
        end
    end

    assign out_valid  = vld_q;
    assign out_sop    = vld_q & word_q.sop & (beat_q == '0);
    assign out_eop    = vld_q & word_q.eop & last_beat;
    assign overflow   = ovf_q;
    assign fifo_level = level_q;

endmodule
